// File: rtl/fpm_bus_master_if.sv
// Request, response and register-bus signals of the FPM bus initiator.
// The master modport is the initiator's view; the slave modport is the requester/register side.
interface fpm_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_opa;
    logic [31:0] req_opb;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_p;
    logic [5:0]  resp_flags;
    logic        resp_timeout;
    logic [1:0]  bus_a;
    logic        bus_we;
    logic [31:0] bus_wd;
    logic [31:0] bus_rd;

    modport master (
        input  req_valid,
        output req_ready,
        input  req_opa,
        input  req_opb,
        output resp_valid,
        input  resp_ready,
        output resp_p,
        output resp_flags,
        output resp_timeout,
        output bus_a,
        output bus_we,
        output bus_wd,
        input  bus_rd
    );

    modport slave (
        output req_valid,
        input  req_ready,
        output req_opa,
        output req_opb,
        input  resp_valid,
        output resp_ready,
        input  resp_p,
        input  resp_flags,
        input  resp_timeout,
        input  bus_a,
        input  bus_we,
        input  bus_wd,
        output bus_rd
    );
endinterface

// File: rtl/fpm_bus_master.sv
// Bus initiator for the FPM register block: writes both operands, pulses start, polls
// the status word until done (or timeout) and returns the product and flags.
module fpm_bus_master #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned TW      = 11
) (
    input  logic              clk,
    input  logic              rst,
    fpm_bus_master_if.master  fpm
);

    localparam logic [1:0] AddrA    = 2'd0;
    localparam logic [1:0] AddrB    = 2'd1;
    localparam logic [1:0] AddrP    = 2'd2;
    localparam logic [1:0] AddrCtrl = 2'd3;

    localparam logic [TW-1:0] PollLast = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWrA,
        StWrB,
        StWrGo,
        StWrClr,
        StPoll,
        StRdP,
        StResp
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   opa_q, opa_d;
    logic [31:0]   opb_q, opb_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [5:0]    flags_q, flags_d;
    logic [31:0]   result_q, result_d;
    logic          timeout_q, timeout_d;
    // Holds req_ready low until the first clock after reset release.
    logic          live_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            opa_q     <= '0;
            opb_q     <= '0;
            cnt_q     <= '0;
            flags_q   <= '0;
            result_q  <= '0;
            timeout_q <= 1'b0;
            live_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            cnt_q     <= cnt_d;
            flags_q   <= flags_d;
            result_q  <= result_d;
            timeout_q <= timeout_d;
            live_q    <= 1'b1;
        end
    end

    always_comb begin
        state_d        = state_q;
        opa_d          = opa_q;
        opb_d          = opb_q;
        cnt_d          = cnt_q;
        flags_d        = flags_q;
        result_d       = result_q;
        timeout_d      = timeout_q;
        fpm.req_ready  = 1'b0;
        fpm.resp_valid = 1'b0;
        fpm.bus_a      = AddrA;
        fpm.bus_we     = 1'b0;
        fpm.bus_wd     = '0;

        unique case (state_q)
            StIdle: begin
                fpm.req_ready = live_q;
                if (live_q && fpm.req_valid) begin
                    opa_d     = fpm.req_opa;
                    opb_d     = fpm.req_opb;
                    timeout_d = 1'b0;
                    state_d   = StWrA;
                end
            end
            StWrA: begin
                fpm.bus_a  = AddrA;
                fpm.bus_we = 1'b1;
                fpm.bus_wd = opa_q;
                state_d    = StWrB;
            end
            StWrB: begin
                fpm.bus_a  = AddrB;
                fpm.bus_we = 1'b1;
                fpm.bus_wd = opb_q;
                state_d    = StWrGo;
            end
            StWrGo: begin
                fpm.bus_a  = AddrCtrl;
                fpm.bus_we = 1'b1;
                fpm.bus_wd = 32'h1;
                state_d    = StWrClr;
            end
            StWrClr: begin
                // Drops the start field; the slave done latch is already clear by now.
                fpm.bus_a  = AddrCtrl;
                fpm.bus_we = 1'b1;
                fpm.bus_wd = 32'h0;
                cnt_d      = '0;
                state_d    = StPoll;
            end
            StPoll: begin
                fpm.bus_a = AddrCtrl;
                if (fpm.bus_rd[0]) begin
                    flags_d = fpm.bus_rd[13:8];
                    state_d = StRdP;
                end else if (cnt_q == PollLast) begin
                    timeout_d = 1'b1;
                    result_d  = '0;
                    flags_d   = '0;
                    state_d   = StResp;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            StRdP: begin
                fpm.bus_a = AddrP;
                result_d  = fpm.bus_rd;
                state_d   = StResp;
            end
            StResp: begin
                fpm.resp_valid = 1'b1;
                if (fpm.resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign fpm.resp_p       = result_q;
    assign fpm.resp_flags   = flags_q;
    assign fpm.resp_timeout = timeout_q;

endmodule

// File: tb/tb_fpm_bus_master.sv
// Directed bench for fpm_bus_master with a small FPM register-block model on the bus side.
module tb_fpm_bus_master;

    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned TW      = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fpm_bus_master_if fpm ();

    fpm_bus_master #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .fpm (fpm)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
        end
    endtask

    // Register-block model: done latch clears on a start write and sets cfg_delay edges later.
    bit [31:0] cfg_prod  = 32'h0;
    bit [5:0]  cfg_flags = 6'h0;
    int        cfg_delay = 1;
    bit        cfg_never = 1'b0;

    bit [31:0] s_a    = 32'h0;
    bit [31:0] s_b    = 32'h0;
    bit        s_done = 1'b0;
    bit        s_busy = 1'b0;
    int        s_cnt  = 0;

    always @(posedge clk) begin
        if (fpm.bus_we && fpm.bus_a == 2'd0) s_a <= fpm.bus_wd;
        if (fpm.bus_we && fpm.bus_a == 2'd1) s_b <= fpm.bus_wd;
        if (fpm.bus_we && fpm.bus_a == 2'd3 && fpm.bus_wd[0]) begin
            s_done <= 1'b0;
            s_cnt  <= cfg_delay;
            s_busy <= 1'b1;
        end else if (s_busy && !cfg_never) begin
            if (s_cnt <= 1) begin
                s_done <= 1'b1;
                s_busy <= 1'b0;
            end else begin
                s_cnt <= s_cnt - 1;
            end
        end
    end

    always_comb begin
        fpm.bus_rd = 32'h0;
        case (fpm.bus_a)
            2'd0: fpm.bus_rd = s_a;
            2'd1: fpm.bus_rd = s_b;
            2'd2: fpm.bus_rd = cfg_prod;
            default: begin
                fpm.bus_rd[0]    = s_done;
                fpm.bus_rd[13:8] = cfg_flags;
            end
        endcase
    end

    // Bus monitor, one entry per bus cycle.
    typedef struct packed {
        logic [1:0]  a;
        logic [31:0] wd;
    } wr_t;

    wr_t wr_log[$];
    bit  poll_log[$];
    int  n_rd = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (fpm.bus_we) wr_log.push_back({fpm.bus_a, fpm.bus_wd});
            else if (fpm.bus_a == 2'd3) poll_log.push_back(fpm.bus_rd[0]);
            else if (fpm.bus_a == 2'd2) n_rd++;
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int budget = 50;
        @(negedge clk);
        fpm.req_valid = 1'b1;
        fpm.req_opa   = a;
        fpm.req_opb   = b;
        while (!fpm.req_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("req_ready_seen", 32'(budget > 0), 32'd1);
        @(negedge clk);
        fpm.req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int cycles);
        int budget = 200;
        cycles = 0;
        while (!fpm.resp_valid && budget > 0) begin
            @(negedge clk);
            budget--;
            cycles++;
        end
        check("resp_valid_seen", 32'(fpm.resp_valid), 32'd1);
    endtask

    task automatic check_resp(input string tag, input logic [31:0] p, input logic [5:0] fl,
                              input logic to);
        check({tag, "_p"}, fpm.resp_p, p);
        check({tag, "_flags"}, 32'(fpm.resp_flags), 32'(fl));
        check({tag, "_timeout"}, 32'(fpm.resp_timeout), 32'(to));
    endtask

    task automatic ack();
        fpm.resp_ready = 1'b1;
        @(negedge clk);
        fpm.resp_ready = 1'b0;
    endtask

    int wb, pb, rb, cyc, budget;
    logic [1:0]  exp_a [4];
    logic [31:0] exp_wd[4];

    initial begin
        fpm.req_valid  = 1'b0;
        fpm.req_opa    = 32'h0;
        fpm.req_opb    = 32'h0;
        fpm.resp_ready = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("rst_req_ready", 32'(fpm.req_ready), 32'd0);
        check("rst_resp_valid", 32'(fpm.resp_valid), 32'd0);
        check("rst_bus_we", 32'(fpm.bus_we), 32'd0);
        check("rst_bus_a", 32'(fpm.bus_a), 32'd0);
        check("rst_bus_wd", fpm.bus_wd, 32'd0);
        check("rst_resp_p", fpm.resp_p, 32'd0);
        check("rst_resp_flags", 32'(fpm.resp_flags), 32'd0);
        check("rst_resp_timeout", 32'(fpm.resp_timeout), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1 check("rel_req_ready_before_clk", 32'(fpm.req_ready), 32'd0);
        @(negedge clk);
        check("rel_req_ready_after_clk", 32'(fpm.req_ready), 32'd1);

        // 1.5 x 2.0 with done four edges after start.
        cfg_prod = 32'h40400000; cfg_flags = 6'h00; cfg_delay = 4; cfg_never = 1'b0;
        wb = wr_log.size(); pb = poll_log.size(); rb = n_rd;
        send(32'h3FC00000, 32'h40000000);
        wait_resp(cyc);
        check_resp("t1", 32'h40400000, 6'h00, 1'b0);
        exp_a  = '{2'd0, 2'd1, 2'd3, 2'd3};
        exp_wd = '{32'h3FC00000, 32'h40000000, 32'h1, 32'h0};
        check("t1_n_writes", 32'(wr_log.size() - wb), 32'd4);
        if (wr_log.size() >= wb + 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("t1_w%0d_a", i), 32'(wr_log[wb+i].a), 32'(exp_a[i]));
                check($sformatf("t1_w%0d_wd", i), wr_log[wb+i].wd, exp_wd[i]);
            end
        end
        check("t1_n_polls", 32'(poll_log.size() - pb), 32'd4);
        check("t1_n_reads", 32'(n_rd - rb), 32'd1);
        ack();

        // inf x 1.0: inff sits at status bit 10, i.e. resp_flags bit 2.
        cfg_prod = 32'h7F800000; cfg_flags = 6'b000100; cfg_delay = 2;
        send(32'h7F800000, 32'h3F800000);
        wait_resp(cyc);
        check_resp("t2", 32'h7F800000, 6'b000100, 1'b0);
        ack();

        // Overflow (of + inff), done on the first poll: minimum latency of six edges.
        cfg_prod = 32'h7F800000; cfg_flags = 6'b100100; cfg_delay = 1;
        pb = poll_log.size();
        send(32'h7F000000, 32'h7F000000);
        wait_resp(cyc);
        check("t3_latency", 32'(cyc), 32'd6);
        check("t3_n_polls", 32'(poll_log.size() - pb), 32'd1);
        check_resp("t3", 32'h7F800000, 6'b100100, 1'b0);
        ack();

        // Done is still set from the last operation until the start write.
        cfg_prod = 32'h40000000; cfg_flags = 6'h00; cfg_delay = 3;
        pb = poll_log.size();
        send(32'h40000000, 32'h3F800000);
        wait_resp(cyc);
        check("t4_first_poll_done", 32'(poll_log[pb]), 32'd0);
        check("t4_n_polls", 32'(poll_log.size() - pb), 32'd3);
        check_resp("t4", 32'h40000000, 6'h00, 1'b0);
        ack();

        // Done never arrives.
        cfg_prod = 32'h12345678; cfg_flags = 6'h3F; cfg_never = 1'b1;
        wb = wr_log.size(); pb = poll_log.size(); rb = n_rd;
        send(32'h3F800000, 32'h3F800000);
        wait_resp(cyc);
        check("t5_n_polls", 32'(poll_log.size() - pb), 32'd16);
        check("t5_n_writes", 32'(wr_log.size() - wb), 32'd4);
        check("t5_n_reads", 32'(n_rd - rb), 32'd0);
        check_resp("t5", 32'h0, 6'h00, 1'b1);
        ack();
        cfg_never = 1'b0; cfg_flags = 6'h00;

        // Response held for 20 cycles with a second request waiting.
        cfg_prod = 32'h40800000; cfg_delay = 2;
        send(32'h40000000, 32'h40000000);
        wait_resp(cyc);
        check_resp("t6a", 32'h40800000, 6'h00, 1'b0);
        cfg_prod      = 32'h40C00000;
        fpm.req_valid = 1'b1;
        fpm.req_opa   = 32'h40400000;
        fpm.req_opb   = 32'h40000000;
        wb = wr_log.size(); pb = poll_log.size();
        repeat (20) begin
            @(negedge clk);
            check("t6_hold_valid", 32'(fpm.resp_valid), 32'd1);
            check("t6_hold_p", fpm.resp_p, 32'h40800000);
            check("t6_hold_req_ready", 32'(fpm.req_ready), 32'd0);
        end
        check("t6_hold_writes", 32'(wr_log.size() - wb), 32'd0);
        check("t6_hold_polls", 32'(poll_log.size() - pb), 32'd0);
        fpm.resp_ready = 1'b1;
        @(negedge clk);
        fpm.resp_ready = 1'b0;
        check("t6_idle_req_ready", 32'(fpm.req_ready), 32'd1);
        check("t6_idle_resp_valid", 32'(fpm.resp_valid), 32'd0);
        @(negedge clk);
        fpm.req_valid = 1'b0;
        check("t6b_we", 32'(fpm.bus_we), 32'd1);
        check("t6b_a", 32'(fpm.bus_a), 32'd0);
        check("t6b_wd", fpm.bus_wd, 32'h40400000);
        wait_resp(cyc);
        check_resp("t6b", 32'h40C00000, 6'h00, 1'b0);
        ack();

        // Asynchronous reset in the middle of polling.
        cfg_never = 1'b1;
        pb = poll_log.size();
        send(32'h3F800000, 32'h40000000);
        budget = 50;
        while (poll_log.size() == pb && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("t7_poll_reached", 32'(budget > 0), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("t7_rst_we", 32'(fpm.bus_we), 32'd0);
        check("t7_rst_a", 32'(fpm.bus_a), 32'd0);
        check("t7_rst_resp_valid", 32'(fpm.resp_valid), 32'd0);
        check("t7_rst_req_ready", 32'(fpm.req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cfg_never = 1'b0; cfg_prod = 32'h3F800000; cfg_delay = 2;
        send(32'h3F800000, 32'h3F800000);
        wait_resp(cyc);
        check_resp("t7", 32'h3F800000, 6'h00, 1'b0);
        ack();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
